// File: rtl/gpio_irq_controller_if.sv
// APB slave bus bundle for gpio_irq_controller.
//   paddr/pwrite/psel/penable/pstrb/pwdata : requester -> controller
//   prdata/pready/pslverr                  : controller -> requester
interface gpio_irq_controller_if;
  logic [15:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (output paddr, pwrite, psel, penable, pstrb, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  paddr, pwrite, psel, penable, pstrb, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/gpio_irq_controller.sv
// gpio_irq_controller: APB GPIO block with atomic set/clear of outputs and
// per-pin edge/level interrupts ORed onto one irq line.
// Ports:
//   sys_clk, rst      : clock, synchronous active-high reset
//   apb (slave)       : zero-wait-state APB, paddr[5:2] decoded
//   gpio_in_data      : asynchronous pad inputs
//   gpio_out_data     : pad output values
//   gpio_out_enable   : pad output enables (1 = drive)
//   irq               : registered OR of enabled status bits
// Optional: define GPIO_DEBOUNCE_EN to add per-pin debounce counters and the
// DB_CNT register at 0x24; otherwise 0x24 is unmapped.

// Per-pin logic: optional debounce, edge history and interrupt status.
module gpio_irq_lane #(
  parameter int DB_CNT_W = 4
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                sync_in,
`ifdef GPIO_DEBOUNCE_EN
  input  logic [DB_CNT_W-1:0] db_cnt,
`endif
  input  logic                irq_type,
  input  logic                irq_pol,
  input  logic                w1c,
  output logic                in_val,
  output logic                status
);
  logic prev;
  logic hit;

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] cnt;
  logic                db_q;

  // Follow the input only after db_cnt+1 consecutive disagreeing samples.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt  <= '0;
      db_q <= 1'b0;
    end else if (sync_in == db_q) begin
      cnt <= '0;
    end else if (cnt == db_cnt) begin
      db_q <= sync_in;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
  assign in_val = db_q;
`else
  wire [DB_CNT_W-1:0] unused_db = '0;
  assign in_val = sync_in;
`endif

  // prev always tracks in_val, so a type/polarity change never fakes an edge.
  assign hit = irq_pol ? (in_val & ~prev) : (~in_val & prev);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      prev   <= 1'b0;
      status <= 1'b0;
    end else begin
      prev <= in_val;
      if (irq_type) status <= (status & ~w1c) | hit;  // set beats clear
      else          status <= (in_val == irq_pol);
    end
  end
endmodule

module gpio_irq_controller #(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  gpio_irq_controller_if.slave  apb,
  input  logic [GPIO_WIDTH-1:0] gpio_in_data,
  output logic [GPIO_WIDTH-1:0] gpio_out_data,
  output logic [GPIO_WIDTH-1:0] gpio_out_enable,
  output logic                  irq
);
  localparam int W = GPIO_WIDTH;

  logic [3:0]   idx;
  logic         addr_ok;
  logic         wr_en;
  logic         rd_setup;
  logic [31:0]  wmask;
  logic [W-1:0] wm, wd, w1c;
  logic [31:0]  rdata;

  logic [W-1:0] out_en, irq_en, irq_type, irq_pol;
  logic [W-1:0] in_val, irq_status;
  logic [SYNC_STAGES-1:0][W-1:0] sync_q;

  wire unused_ok = ^{apb.paddr[15:6], apb.paddr[1:0], apb.pwdata, wmask};

  assign idx      = apb.paddr[5:2];
  assign wmask    = {{8{apb.pstrb[3]}}, {8{apb.pstrb[2]}},
                     {8{apb.pstrb[1]}}, {8{apb.pstrb[0]}}};
  assign wm       = wmask[W-1:0];
  assign wd       = apb.pwdata[W-1:0] & wm;
  assign wr_en    = apb.psel & apb.penable & apb.pwrite & addr_ok;
  assign rd_setup = apb.psel & ~apb.penable & ~apb.pwrite;
  assign w1c      = (wr_en && idx == 4'd6) ? wd : '0;
  assign apb.pready = 1'b1;

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] db_cnt;
  assign addr_ok = (idx <= 4'd9);
`else
  wire [DB_CNT_W-1:0] unused_db = '0;
  assign addr_ok = (idx <= 4'd8);
`endif

  // Register file writes; byte strobes mask every written register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      gpio_out_data <= '0;
      out_en        <= '0;
      irq_en        <= '0;
      irq_type      <= '0;
      irq_pol       <= '0;
`ifdef GPIO_DEBOUNCE_EN
      db_cnt        <= '0;
`endif
    end else if (wr_en) begin
      case (idx)
        4'd0: gpio_out_data <= (gpio_out_data & ~wm) | wd;
        4'd1: out_en        <= (out_en & ~wm) | wd;
        4'd3: irq_en        <= (irq_en & ~wm) | wd;
        4'd4: irq_type      <= (irq_type & ~wm) | wd;
        4'd5: irq_pol       <= (irq_pol & ~wm) | wd;
        4'd7: gpio_out_data <= gpio_out_data | wd;
        4'd8: gpio_out_data <= gpio_out_data & ~wd;
`ifdef GPIO_DEBOUNCE_EN
        4'd9: db_cnt <= (db_cnt & ~wmask[DB_CNT_W-1:0]) |
                        (apb.pwdata[DB_CNT_W-1:0] & wmask[DB_CNT_W-1:0]);
`endif
        default: ;
      endcase
    end
  end
  assign gpio_out_enable = out_en;

  // Input synchroniser; stage SYNC_STAGES-1 is the settled value.
  always_ff @(posedge sys_clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in_data};
  end

  for (genvar i = 0; i < W; i++) begin : g_lane
    gpio_irq_lane #(.DB_CNT_W(DB_CNT_W)) u_lane (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .sync_in  (sync_q[SYNC_STAGES-1][i]),
`ifdef GPIO_DEBOUNCE_EN
      .db_cnt   (db_cnt),
`endif
      .irq_type (irq_type[i]),
      .irq_pol  (irq_pol[i]),
      .w1c      (w1c[i]),
      .in_val   (in_val[i]),
      .status   (irq_status[i])
    );
  end

  always_comb begin
    rdata = '0;
    case (idx)
      4'd0: rdata[W-1:0] = gpio_out_data;
      4'd1: rdata[W-1:0] = out_en;
      4'd2: rdata[W-1:0] = in_val;
      4'd3: rdata[W-1:0] = irq_en;
      4'd4: rdata[W-1:0] = irq_type;
      4'd5: rdata[W-1:0] = irq_pol;
      4'd6: rdata[W-1:0] = irq_status;
`ifdef GPIO_DEBOUNCE_EN
      4'd9: rdata[DB_CNT_W-1:0] = db_cnt;
`endif
      default: ;
    endcase
  end

  // Setup edge captures read data and the error flag, so both are stable
  // for the access phase; pslverr falls back to 0 on the access edge.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      apb.prdata  <= '0;
      apb.pslverr <= 1'b0;
      irq         <= 1'b0;
    end else begin
      apb.pslverr <= apb.psel & ~apb.penable & ~addr_ok;
      if (rd_setup) apb.prdata <= rdata;
      irq <= |(irq_status & irq_en);
    end
  end
endmodule
